// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus CPU: fetch (T0-T2), execute (T3-T6), halt.
// Optional SINGLE_STEP_EN: one instruction per rising edge of step (run still required).
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  input  logic             step,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic [4:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t state, next_state, retire_state;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic is_alu, is_muldiv, is_nop, is_halt;
  logic start, retire;
  logic unused_bits;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  always_comb begin
    is_alu    = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001};
    is_muldiv = op inside {5'b01111, 5'b10000};
    is_nop    = (op == 5'b11010);
    is_halt   = (op == 5'b11011);
  end

`ifdef SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign start        = run & step & ~step_q;
  assign retire_state = IDLE;
  assign unused_bits  = ^ir[14:0];
`else
  assign start        = run;
  assign retire_state = run ? T0 : IDLE;
  assign unused_bits  = ^{ir[14:0], step};
`endif

  // Nop, halt and undefined opcodes all finish in T3.
  assign retire = ((state == T3) && !is_alu && !is_muldiv) ||
                  ((state == T5) && is_alu) ||
                  (state == T6);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = T0;
      T0:   next_state = T1;
      T1:   if (mem_ready) next_state = T2;
      T2:   next_state = T3;
      T3: begin
        if (is_alu || is_muldiv) next_state = T4;
        else if (is_halt)        next_state = HALT;
        else                     next_state = retire_state;
      end
      T4:   next_state = T5;
      T5:   next_state = is_muldiv ? T6 : retire_state;
      T6:   next_state = retire_state;
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    reg_in   = '0;
    reg_out  = '0;
    alu_op   = '0;
    halted   = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          reg_out[rb] = 1'b1;
          Yin         = 1'b1;
        end else if (is_muldiv) begin
          reg_out[ra] = 1'b1;
          Yin         = 1'b1;
        end else if (!is_nop && !is_halt) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (is_alu) reg_out[rc] = 1'b1;
        else        reg_out[rb] = 1'b1;
        alu_op = op;
        Zin    = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           reg_in[ra] = 1'b1;
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer, plus hand sequences for clear, wrap and single-step.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic clear, run, mem_ready, step;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
  logic IRin, Yin, HIin, LOin, IncPC, Read, halted, illegal;
  logic [15:0] reg_in, reg_out;
  logic [4:0]  alu_op;
  logic [3:0]  instr_count;
  logic [15:0] strb;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.NREGS(16), .CNT_W(4)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready), .step(step),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  assign strb = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
                 IRin, Yin, HIin, LOin, IncPC, Read, halted, illegal};

  localparam logic [15:0] S_T0   = 16'h8C08; // PCout MARin Zin IncPC
  localparam logic [15:0] S_T1   = 16'h4304; // Zlowout PCin MDRin Read
  localparam logic [15:0] S_T1W  = 16'h4104; // T1 while waiting: no PCin
  localparam logic [15:0] S_T2   = 16'h1080; // MDRout IRin
  localparam logic [15:0] S_YIN  = 16'h0040;
  localparam logic [15:0] S_ZIN  = 16'h0400;
  localparam logic [15:0] S_ZLO  = 16'h4000;
  localparam logic [15:0] S_LO   = 16'h4010; // Zlowout LOin
  localparam logic [15:0] S_HI   = 16'h2020; // Zhighout HIin
  localparam logic [15:0] S_HALT = 16'h0002;
  localparam logic [15:0] S_ILL  = 16'h0001;

  localparam logic [31:0] ADD  = 32'h1A920000;
  localparam logic [31:0] MUL  = 32'h79880000;
  localparam logic [31:0] HLT  = 32'hD8000000;
  localparam logic [31:0] NOP  = 32'hD0000000;
  localparam logic [31:0] ILL  = 32'hF8000000;

  typedef struct {
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [15:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t v(input logic r, input logic m, input logic [31:0] i,
                             input logic [15:0] s, input logic [15:0] ri,
                             input logic [15:0] ro, input logic [4:0] a, input logic [3:0] c);
    vec_t x;
    x.run = r; x.mr = m; x.ir = i; x.strb = s; x.rin = ri; x.rout = ro; x.alu = a; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".strb"}, {16'h0, strb}, 32'h0);
    chk({name, ".reg"}, {reg_in, reg_out}, 32'h0);
    chk({name, ".alu"}, {27'h0, alu_op}, 32'h0);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; mem_ready = 1'b1; step = 1'b0; ir = '0;

    // row: run, mem_ready, ir, strobes, reg_in, reg_out, alu_op, count
    tbl[0]  = v(1, 1, 32'h0, 16'h0,  16'h0,    16'h0,    5'h00, 4'd0); // IDLE
    tbl[1]  = v(1, 1, 32'h0, S_T0,   16'h0,    16'h0,    5'h00, 4'd0);
    tbl[2]  = v(1, 1, 32'h0, S_T1,   16'h0,    16'h0,    5'h00, 4'd0);
    tbl[3]  = v(1, 1, ADD,   S_T2,   16'h0,    16'h0,    5'h00, 4'd0);
    tbl[4]  = v(1, 1, ADD,   S_YIN,  16'h0,    16'h0004, 5'h00, 4'd0);
    tbl[5]  = v(1, 1, ADD,   S_ZIN,  16'h0,    16'h0010, 5'h03, 4'd0);
    tbl[6]  = v(1, 1, ADD,   S_ZLO,  16'h0020, 16'h0,    5'h00, 4'd0);
    tbl[7]  = v(1, 1, ADD,   S_T0,   16'h0,    16'h0,    5'h00, 4'd1);
    tbl[8]  = v(1, 0, ADD,   S_T1W,  16'h0,    16'h0,    5'h00, 4'd1);
    tbl[9]  = v(1, 0, ADD,   S_T1W,  16'h0,    16'h0,    5'h00, 4'd1);
    tbl[10] = v(1, 0, ADD,   S_T1W,  16'h0,    16'h0,    5'h00, 4'd1);
    tbl[11] = v(1, 1, ADD,   S_T1,   16'h0,    16'h0,    5'h00, 4'd1);
    tbl[12] = v(1, 1, MUL,   S_T2,   16'h0,    16'h0,    5'h00, 4'd1);
    tbl[13] = v(1, 1, MUL,   S_YIN,  16'h0,    16'h0008, 5'h00, 4'd1);
    tbl[14] = v(0, 1, MUL,   S_ZIN,  16'h0,    16'h0002, 5'h0F, 4'd1);
    tbl[15] = v(0, 1, MUL,   S_LO,   16'h0,    16'h0,    5'h00, 4'd1);
    tbl[16] = v(0, 1, MUL,   S_HI,   16'h0,    16'h0,    5'h00, 4'd1);
    tbl[17] = v(0, 1, MUL,   16'h0,  16'h0,    16'h0,    5'h00, 4'd2);
    tbl[18] = v(1, 1, MUL,   16'h0,  16'h0,    16'h0,    5'h00, 4'd2);
    tbl[19] = v(1, 1, ILL,   S_T0,   16'h0,    16'h0,    5'h00, 4'd2);
    tbl[20] = v(1, 1, ILL,   S_T1,   16'h0,    16'h0,    5'h00, 4'd2);
    tbl[21] = v(1, 1, ILL,   S_T2,   16'h0,    16'h0,    5'h00, 4'd2);
    tbl[22] = v(1, 1, ILL,   S_ILL,  16'h0,    16'h0,    5'h00, 4'd2);
    tbl[23] = v(1, 1, HLT,   S_T0,   16'h0,    16'h0,    5'h00, 4'd3);
    tbl[24] = v(1, 1, HLT,   S_T1,   16'h0,    16'h0,    5'h00, 4'd3);
    tbl[25] = v(1, 1, HLT,   S_T2,   16'h0,    16'h0,    5'h00, 4'd3);
    tbl[26] = v(1, 1, HLT,   16'h0,  16'h0,    16'h0,    5'h00, 4'd3);
    tbl[27] = v(1, 1, HLT,   S_HALT, 16'h0,    16'h0,    5'h00, 4'd4);
    tbl[28] = v(1, 1, HLT,   S_HALT, 16'h0,    16'h0,    5'h00, 4'd4);
    tbl[29] = v(1, 1, HLT,   S_HALT, 16'h0,    16'h0,    5'h00, 4'd4);

    // Outputs during clear
    repeat (2) @(posedge clock);
    #2;
    chk_zero("reset");
    chk("reset.cnt", {28'h0, instr_count}, 32'h0);
    @(posedge clock);
    #1;
    clear = 1'b0;

`ifndef SINGLE_STEP_EN
    for (int i = 0; i < 30; i++) begin
      run = tbl[i].run; mem_ready = tbl[i].mr; ir = tbl[i].ir;
      #1;
      chk($sformatf("row%0d.strb", i), {16'h0, strb}, {16'h0, tbl[i].strb});
      chk($sformatf("row%0d.reg_in", i), {16'h0, reg_in}, {16'h0, tbl[i].rin});
      chk($sformatf("row%0d.reg_out", i), {16'h0, reg_out}, {16'h0, tbl[i].rout});
      chk($sformatf("row%0d.alu_op", i), {27'h0, alu_op}, {27'h0, tbl[i].alu});
      chk($sformatf("row%0d.cnt", i), {28'h0, instr_count}, {28'h0, tbl[i].cnt});
      @(posedge clock);
      #1;
    end

    // Clear out of HALT
    #1;
    clear = 1'b1;
    #1;
    chk_zero("halt_clear");
    chk("halt_clear.cnt", {28'h0, instr_count}, 32'h0);
    @(negedge clock);
    clear = 1'b0; run = 1'b0;
    @(posedge clock);
    #2;
    chk_zero("idle_norun");

    // Clear during a T1 memory wait
    run = 1'b1; mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("t1wait.strb", {16'h0, strb}, {16'h0, S_T1W});
    clear = 1'b1;
    #1;
    chk_zero("t1wait_clear");
    @(negedge clock);
    clear = 1'b0; mem_ready = 1'b1; ir = NOP;

    // Nop stream: counter wraps 15 -> 0 (each nop is 4 cycles)
    repeat (4) @(posedge clock);
    #2;
    chk("nop_t3.strb", {16'h0, strb}, 32'h0);
    repeat (57) @(posedge clock);
    #2;
    chk("wrap15.cnt", {28'h0, instr_count}, 32'd15);
    chk("wrap15.strb", {16'h0, strb}, {16'h0, S_T0});
    repeat (4) @(posedge clock);
    #2;
    chk("wrap0.cnt", {28'h0, instr_count}, 32'd0);
    chk("wrap0.strb", {16'h0, strb}, {16'h0, S_T0});
`else
    // One nop per rising edge of step; a held step does not re-trigger
    run = 1'b1; mem_ready = 1'b1; ir = NOP;
    repeat (3) @(posedge clock);
    #2;
    chk("ss_wait.strb", {16'h0, strb}, 32'h0);
    @(negedge clock);
    step = 1'b1;
    @(posedge clock);
    #2;
    chk("ss_go1.strb", {16'h0, strb}, {16'h0, S_T0});
    repeat (4) @(posedge clock);
    #2;
    chk("ss_done1.strb", {16'h0, strb}, 32'h0);
    chk("ss_done1.cnt", {28'h0, instr_count}, 32'd1);
    repeat (5) @(posedge clock);
    #2;
    chk("ss_held.strb", {16'h0, strb}, 32'h0);
    chk("ss_held.cnt", {28'h0, instr_count}, 32'd1);
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    step = 1'b1;
    @(posedge clock);
    #2;
    chk("ss_go2.strb", {16'h0, strb}, {16'h0, S_T0});
    repeat (4) @(posedge clock);
    #2;
    chk("ss_done2.strb", {16'h0, strb}, 32'h0);
    chk("ss_done2.cnt", {28'h0, instr_count}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
